// File: rtl/rom_sdram_loader_pkg.sv
// Shared types and constants for the ROM download to SDRAM loader.
// Holds the FSM state encoding, byte-select codes and the saturating byte counter helper.
package m72_loader_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        HOLD   = 2'd2,
        BUSY   = 2'd3
    } state_t;

    localparam logic [1:0]  SEL_LO            = 2'b01;
    localparam logic [1:0]  SEL_HI            = 2'b10;
    localparam logic [1:0]  SEL_W             = 2'b11;
    localparam logic [7:0]  ROM_INDEX_DEFAULT = 8'd0;
    localparam logic [24:0] BYTES_MAX         = 25'h1FFFFFF;

    function automatic logic [24:0] sat_add(input logic [24:0] cnt, input logic [1:0] sel);
        logic [25:0] sum;
        sum = {1'b0, cnt} + 26'(sel[0]) + 26'(sel[1]);
        sat_add = sum[25] ? BYTES_MAX : sum[24:0];
    endfunction

endpackage

// File: rtl/rom_sdram_loader_if.sv
// HPS ioctl download stream plus SDRAM port-0 toggle handshake, bundled for the loader.
// master = loader side (drives SDRAM request, stalls HPS); slave = HPS + SDRAM side.
interface rom_sdram_loader_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic [23:0] sdr_addr;
    logic [15:0] sdr_din;
    logic [1:0]  sdr_wr_sel;
    logic        sdr_req;
    logic        sdr_ack;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        output ioctl_wait, sdr_addr, sdr_din, sdr_wr_sel, sdr_req
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        input  ioctl_wait, sdr_addr, sdr_din, sdr_wr_sel, sdr_req
    );

endinterface

// File: rtl/rom_sdram_loader_toggle_sync.sv
// Two-flop synchroniser for a level/toggle signal crossing into clk_i.
// Latency 2 cycles; no flow control.
module toggle_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rom_sdram_loader.sv
// Packs HPS ROM download bytes into 16-bit SDRAM port-0 writes on a toggle req/ack handshake.
// One write in flight; ioctl_wait stalls the HPS from issue until the synchronised ack matches req.
module rom_sdram_loader
    import m72_loader_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX  = ROM_INDEX_DEFAULT,
    parameter logic [24:0] ADDR_LIMIT = 25'h1000000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    rom_sdram_loader_if.master bus,
    output logic               rom_done,
    output logic [24:0]        rom_bytes,
    output logic               load_err
);

    logic ack_s;

    toggle_sync u_ack_sync (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .d_i    (bus.sdr_ack),
        .q_o    (ack_s)
    );

    state_t      state_q, state_d;
    logic [1:0]  rs_cnt_q, rs_cnt_d;
    logic        req_q, req_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [1:0]  sel_q, sel_d;
    logic        wait_q, wait_d;
    logic [7:0]  lo_q, lo_d;
    logic [23:0] lo_addr_q, lo_addr_d;
    logic        pend_vld_q, pend_vld_d;
    logic [24:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_dat_q, pend_dat_d;
    logic        rom_act_q, rom_act_d;
    logic        end_pend_q, end_pend_d;
    logic        done_q, done_d;
    logic [24:0] bytes_q, bytes_d;
    logic        err_q, err_d;

    logic        idx_ok, strobe, in_range;
    logic        take_vld;
    logic [24:0] take_addr;
    logic [7:0]  take_dat;
    logic        iss_vld;
    logic [23:0] iss_addr;
    logic [15:0] iss_din;
    logic [1:0]  iss_sel;

    assign idx_ok   = (bus.ioctl_index == ROM_INDEX);
    assign strobe   = bus.ioctl_wr & bus.ioctl_download & idx_ok;
    assign in_range = (bus.ioctl_addr < ADDR_LIMIT);

    always_comb begin
        state_d     = state_q;
        rs_cnt_d    = rs_cnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        din_d       = din_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        lo_d        = lo_q;
        lo_addr_d   = lo_addr_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_dat_d  = pend_dat_q;
        rom_act_d   = rom_act_q;
        end_pend_d  = end_pend_q;
        done_d      = done_q;
        bytes_d     = bytes_q;
        err_d       = err_q;
        take_vld    = 1'b0;
        take_addr   = '0;
        take_dat    = '0;
        iss_vld     = 1'b0;
        iss_addr    = '0;
        iss_din     = '0;
        iss_sel     = '0;

        unique case (state_q)
            // Track ack until the synchroniser has flushed its reset value, then align req to it.
            RESYNC: begin
                req_d    = ack_s;
                rs_cnt_d = rs_cnt_q + 2'd1;
                if (rs_cnt_q == 2'd2) state_d = IDLE;
            end
            IDLE: begin
                if (strobe && in_range) begin
                    take_vld  = 1'b1;
                    take_addr = bus.ioctl_addr;
                    take_dat  = bus.ioctl_dout;
                end else if (strobe) begin
                    err_d = 1'b1;
                end
            end
            HOLD: begin
                if (strobe && !in_range) begin
                    err_d = 1'b1;
                end else if (strobe) begin
                    iss_vld  = 1'b1;
                    iss_addr = lo_addr_q;
                    if (bus.ioctl_addr[0] && (bus.ioctl_addr[24:1] == lo_addr_q)) begin
                        iss_din = {bus.ioctl_dout, lo_q};
                        iss_sel = SEL_W;
                    end else begin
                        iss_din     = {8'h00, lo_q};
                        iss_sel     = SEL_LO;
                        pend_vld_d  = 1'b1;
                        pend_addr_d = bus.ioctl_addr;
                        pend_dat_d  = bus.ioctl_dout;
                    end
                end else if (!bus.ioctl_download) begin
                    iss_vld  = 1'b1;
                    iss_addr = lo_addr_q;
                    iss_din  = {8'h00, lo_q};
                    iss_sel  = SEL_LO;
                end
            end
            BUSY: begin
                if (strobe) err_d = 1'b1;
                if (ack_s == req_q) begin
                    wait_d  = 1'b0;
                    bytes_d = sat_add(bytes_q, sel_q);
                    state_d = IDLE;
                    if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        take_vld   = 1'b1;
                        take_addr  = pend_addr_q;
                        take_dat   = pend_dat_q;
                    end
                end
            end
        endcase

        if (take_vld) begin
            if (take_addr[0]) begin
                iss_vld  = 1'b1;
                iss_addr = take_addr[24:1];
                iss_din  = {take_dat, 8'h00};
                iss_sel  = SEL_HI;
            end else begin
                lo_d      = take_dat;
                lo_addr_d = take_addr[24:1];
                state_d   = HOLD;
            end
        end

        if (iss_vld) begin
            addr_d  = iss_addr;
            din_d   = iss_din;
            sel_d   = iss_sel;
            req_d   = ~req_q;
            wait_d  = 1'b1;
            state_d = BUSY;
        end

        if (end_pend_q && (state_q == IDLE) && !pend_vld_q) begin
            done_d     = 1'b1;
            end_pend_d = 1'b0;
        end
        if (rom_act_q && !bus.ioctl_download) begin
            rom_act_d  = 1'b0;
            end_pend_d = 1'b1;
        end
        if (bus.ioctl_download && idx_ok && !rom_act_q) begin
            rom_act_d  = 1'b1;
            end_pend_d = 1'b0;
            done_d     = 1'b0;
            bytes_d    = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESYNC;
            rs_cnt_q    <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            sel_q       <= '0;
            wait_q      <= 1'b0;
            lo_q        <= '0;
            lo_addr_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_dat_q  <= '0;
            rom_act_q   <= 1'b0;
            end_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            bytes_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_cnt_q    <= rs_cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            lo_q        <= lo_d;
            lo_addr_q   <= lo_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_dat_q  <= pend_dat_d;
            rom_act_q   <= rom_act_d;
            end_pend_q  <= end_pend_d;
            done_q      <= done_d;
            bytes_q     <= bytes_d;
            err_q       <= err_d;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.sdr_req    = req_q;
    assign bus.sdr_addr   = addr_q;
    assign bus.sdr_din    = din_q;
    assign bus.sdr_wr_sel = sel_q;
    assign rom_done       = done_q;
    assign rom_bytes      = bytes_q;
    assign load_err       = err_q;

endmodule

// File: tb/tb_rom_sdram_loader.sv
// Bench for rom_sdram_loader: HPS byte driver, SDRAM toggle-ack responder and a write scoreboard.
module tb_rom_sdram_loader;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  sel;
    } wr_t;

    localparam int ACK_DLY = 4;

    logic        clk_sys;
    logic        reset_n;
    logic        rom_done;
    logic [24:0] rom_bytes;
    logic        load_err;

    int   checks = 0;
    int   fails  = 0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    logic prev_req = 1'b0;
    logic model_en = 1'b0;
    logic ack_pend = 1'b0;
    logic ack_tgt  = 1'b0;
    int   ack_cnt  = 0;

    rom_sdram_loader_if bus ();

    rom_sdram_loader #(
        .ROM_INDEX  (8'd0),
        .ADDR_LIMIT (25'h1000000)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .bus       (bus),
        .rom_done  (rom_done),
        .rom_bytes (rom_bytes),
        .load_err  (load_err)
    );

    initial clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    // One clock step; also plays the SDRAM: a req edge that leaves req != ack is a new write.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (bus.sdr_req !== prev_req && bus.sdr_req !== bus.sdr_ack) begin
            obs_q.push_back(wr_t'{addr: bus.sdr_addr, din: bus.sdr_din, sel: bus.sdr_wr_sel});
            if (model_en) begin
                ack_pend = 1'b1;
                ack_tgt  = bus.sdr_req;
                ack_cnt  = ACK_DLY;
            end
        end
        prev_req = bus.sdr_req;
        if (ack_pend) begin
            if (ack_cnt <= 1) begin
                bus.sdr_ack = ack_tgt;
                ack_pend    = 1'b0;
            end else begin
                ack_cnt--;
            end
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output logic w1, output int bc);
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        w1 = bus.ioctl_wait;
        bc = 0;
        while (bus.ioctl_wait === 1'b1 && bc < 50) begin
            tick();
            bc++;
        end
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    task automatic dl_end();
        bus.ioctl_download = 1'b0;
        for (int n = 0; n < 80 && rom_done !== 1'b1; n++) tick();
    endtask

    task automatic test_reset();
        wr_t  e, o;
        logic w1;
        int   bc;
        reset_n            = 1'b1;
        bus.sdr_ack        = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ioctl_wait, bus.sdr_req, bus.sdr_wr_sel} !== 4'b0000)
            begin fails++; $display("FAIL rst_ctl got wait/req/sel=%b want 0000", {bus.ioctl_wait, bus.sdr_req, bus.sdr_wr_sel}); end
        checks++;
        if (bus.sdr_addr !== 24'd0 || bus.sdr_din !== 16'd0)
            begin fails++; $display("FAIL rst_bus got addr=%h din=%h want 0", bus.sdr_addr, bus.sdr_din); end
        checks++;
        if (rom_done !== 1'b0 || rom_bytes !== 25'd0 || load_err !== 1'b0)
            begin fails++; $display("FAIL rst_status got done=%b bytes=%0d err=%b want 0", rom_done, rom_bytes, load_err); end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.sdr_req !== 1'b1) begin fails++; $display("FAIL rst_resync_req got %b want 1", bus.sdr_req); end
        checks++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL rst_no_write got %0d writes want 0", obs_q.size()); end
        model_en = 1'b1;
        dl_begin(8'd0);
        send_byte(25'h10, 8'hAB, w1, bc);
        checks++;
        if (w1 !== 1'b0) begin fails++; $display("FAIL rst_even_wait got %b want 0", w1); end
        send_byte(25'h11, 8'hCD, w1, bc);
        exp_q.push_back(wr_t'{addr: 24'h8, din: 16'hCDAB, sel: 2'b11});
        checks++;
        if (w1 !== 1'b1) begin fails++; $display("FAIL rst_odd_wait got %b want 1", w1); end
        checks++;
        if (bus.sdr_req !== 1'b0) begin fails++; $display("FAIL rst_req_toggle got %b want 0", bus.sdr_req); end
        dl_end();
        checks++;
        if (rom_done !== 1'b1 || rom_bytes !== 25'd2)
            begin fails++; $display("FAIL rst_done got done=%b bytes=%0d want 1/2", rom_done, rom_bytes); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL rst_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stream();
        wr_t  e, o;
        logic w1;
        int   bc;
        logic [7:0] b [8];
        dl_begin(8'd0);
        checks++;
        if (rom_done !== 1'b0 || rom_bytes !== 25'd0)
            begin fails++; $display("FAIL stream_start got done=%b bytes=%0d want 0/0", rom_done, rom_bytes); end
        for (int i = 0; i < 8; i++) begin
            b[i] = 8'h30 + 8'(i * 7);
            send_byte(25'(i), b[i], w1, bc);
            if (i % 2 == 1) exp_q.push_back(wr_t'{addr: 24'(i / 2), din: {b[i], b[i-1]}, sel: 2'b11});
            checks++;
            if (w1 !== ((i % 2) == 1)) begin fails++; $display("FAIL stream_wait byte %0d got %b want %b", i, w1, (i % 2) == 1); end
            checks++;
            if (bc != ((i % 2 == 1) ? ACK_DLY + 2 : 0)) begin fails++; $display("FAIL stream_busy byte %0d got %0d want %0d", i, bc, (i % 2 == 1) ? ACK_DLY + 2 : 0); end
        end
        dl_end();
        checks++;
        if (rom_done !== 1'b1 || rom_bytes !== 25'd8 || load_err !== 1'b0)
            begin fails++; $display("FAIL stream_end got done=%b bytes=%0d err=%b want 1/8/0", rom_done, rom_bytes, load_err); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL stream_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL stream_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_odd_len();
        wr_t  e, o;
        logic w1;
        int   bc;
        logic [7:0] b [5];
        dl_begin(8'd0);
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'h90 + 8'(i);
            send_byte(25'(i), b[i], w1, bc);
        end
        exp_q.push_back(wr_t'{addr: 24'd0, din: {b[1], b[0]}, sel: 2'b11});
        exp_q.push_back(wr_t'{addr: 24'd1, din: {b[3], b[2]}, sel: 2'b11});
        exp_q.push_back(wr_t'{addr: 24'd2, din: {8'h00, b[4]}, sel: 2'b01});
        repeat (3) tick();
        checks++;
        if (obs_q.size() != 2) begin fails++; $display("FAIL odd_held got %0d writes want 2", obs_q.size()); end
        dl_end();
        checks++;
        if (rom_done !== 1'b1 || rom_bytes !== 25'd5)
            begin fails++; $display("FAIL odd_end got done=%b bytes=%0d want 1/5", rom_done, rom_bytes); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL odd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL odd_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_nonseq();
        wr_t  e, o;
        logic w1;
        int   bc;
        dl_begin(8'd0);
        send_byte(25'h20, 8'h5A, w1, bc);
        send_byte(25'h41, 8'hA5, w1, bc);
        exp_q.push_back(wr_t'{addr: 24'h10, din: 16'h005A, sel: 2'b01});
        exp_q.push_back(wr_t'{addr: 24'h20, din: 16'hA500, sel: 2'b10});
        checks++;
        if (w1 !== 1'b1 || bc >= 50) begin fails++; $display("FAIL nonseq_wait got wait=%b cycles=%0d want 1/<50", w1, bc); end
        dl_end();
        checks++;
        if (rom_done !== 1'b1 || rom_bytes !== 25'd2)
            begin fails++; $display("FAIL nonseq_end got done=%b bytes=%0d want 1/2", rom_done, rom_bytes); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL nonseq_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL nonseq_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_errors();
        wr_t  e, o;
        logic w1;
        int   bc;
        dl_begin(8'd0);
        send_byte(25'h0, 8'h11, w1, bc);
        bus.ioctl_addr = 25'h1;
        bus.ioctl_dout = 8'h22;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_addr = 25'h2;
        bus.ioctl_dout = 8'h33;
        tick();
        bus.ioctl_wr = 1'b0;
        for (int n = 0; n < 50 && bus.ioctl_wait === 1'b1; n++) tick();
        exp_q.push_back(wr_t'{addr: 24'h0, din: 16'h2211, sel: 2'b11});
        checks++;
        if (load_err !== 1'b1) begin fails++; $display("FAIL err_busy got %b want 1", load_err); end
        dl_end();
        checks++;
        if (rom_bytes !== 25'd2) begin fails++; $display("FAIL err_busy_bytes got %0d want 2", rom_bytes); end
        dl_begin(8'd0);
        checks++;
        if (load_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", load_err); end
        send_byte(25'h40, 8'h44, w1, bc);
        send_byte(25'h41, 8'h55, w1, bc);
        exp_q.push_back(wr_t'{addr: 24'h20, din: 16'h5544, sel: 2'b11});
        send_byte(25'h1000000, 8'h66, w1, bc);
        repeat (8) tick();
        checks++;
        if (w1 !== 1'b0 || load_err !== 1'b1 || rom_bytes !== 25'd2)
            begin fails++; $display("FAIL err_range got wait=%b err=%b bytes=%0d want 0/1/2", w1, load_err, rom_bytes); end
        dl_end();
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL err_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_busy();
        wr_t  e, o;
        logic w1;
        int   bc;
        logic req0;
        req0     = bus.sdr_req;
        model_en = 1'b0;
        dl_begin(8'd0);
        send_byte(25'h30, 8'h77, w1, bc);
        bus.ioctl_addr = 25'h31;
        bus.ioctl_dout = 8'h88;
        bus.ioctl_wr   = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        tick();
        tick();
        exp_q.push_back(wr_t'{addr: 24'h18, din: 16'h8877, sel: 2'b11});
        checks++;
        if (bus.ioctl_wait !== 1'b1 || bus.sdr_req !== ~req0)
            begin fails++; $display("FAIL rb_busy got wait=%b req=%b want 1/%b", bus.ioctl_wait, bus.sdr_req, ~req0); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rb_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin fails++; $display("FAIL rb_write got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ioctl_wait, bus.sdr_req, bus.sdr_wr_sel} !== 4'b0000 || bus.sdr_addr !== 24'd0 || bus.sdr_din !== 16'd0)
            begin fails++; $display("FAIL rb_async got wait/req/sel=%b addr=%h din=%h want 0", {bus.ioctl_wait, bus.sdr_req, bus.sdr_wr_sel}, bus.sdr_addr, bus.sdr_din); end
        checks++;
        if (rom_done !== 1'b0 || rom_bytes !== 25'd0 || load_err !== 1'b0)
            begin fails++; $display("FAIL rb_async_status got done=%b bytes=%0d err=%b want 0", rom_done, rom_bytes, load_err); end
        bus.ioctl_download = 1'b0;
        tick();
        bus.sdr_ack = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (bus.sdr_req !== 1'b1 || bus.ioctl_wait !== 1'b0)
            begin fails++; $display("FAIL rb_resync got req=%b wait=%b want 1/0", bus.sdr_req, bus.ioctl_wait); end
        checks++;
        if (obs_q.size() != 0) begin fails++; $display("FAIL rb_spurious got %0d writes want 0", obs_q.size()); end
        model_en = 1'b1;
        dl_begin(8'd1);
        send_byte(25'h0, 8'hE1, w1, bc);
        checks++;
        if (w1 !== 1'b0) begin fails++; $display("FAIL idx_wait_even got %b want 0", w1); end
        send_byte(25'h1, 8'hE2, w1, bc);
        checks++;
        if (w1 !== 1'b0) begin fails++; $display("FAIL idx_wait_odd got %b want 0", w1); end
        bus.ioctl_download = 1'b0;
        repeat (8) tick();
        checks++;
        if (obs_q.size() != 0 || bus.sdr_req !== 1'b1 || rom_bytes !== 25'd0 || rom_done !== 1'b0)
            begin fails++; $display("FAIL idx_ignore got writes=%0d req=%b bytes=%0d done=%b want 0/1/0/0", obs_q.size(), bus.sdr_req, rom_bytes, rom_done); end
        bus.ioctl_index = 8'd0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_odd_len();
        test_nonseq();
        test_errors();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
